// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO into a valid/ready stream. A 3-entry buffer absorbs
// the FIFO's one-cycle read latency so m_ready never reaches fifo_r_en combinationally.
module fifo_stream_reader #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_r_en,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data,
  input  logic             m_ready,
  output logic [CNT_W-1:0] words_out,
  output logic             busy
);

  logic [WIDTH-1:0] buf_q [3];
  logic [WIDTH-1:0] buf_d [3];
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic             inflight_q, inflight_d;
  logic [CNT_W-1:0] words_out_q, words_out_d;
  logic             pop_s;
  logic [2:0]       credit_s;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    if (p == 2'd2) begin
      return 2'd0;
    end else begin
      return p + 2'd1;
    end
  endfunction

  // Read issue, stream outputs and status, all from registered state.
  always_comb begin
    // Words already read but not yet delivered; a new read needs a free slot.
    credit_s  = {1'b0, occ_q} + {2'b00, inflight_q};
    fifo_r_en = en && !rst && !fifo_empty && (credit_s < 3'd3);
    m_valid   = (occ_q != 2'd0);
    case (rd_ptr_q)
      2'd1:    m_data = buf_q[1];
      2'd2:    m_data = buf_q[2];
      default: m_data = buf_q[0];
    endcase
    pop_s     = m_valid && m_ready;
    busy      = m_valid || inflight_q;
    words_out = words_out_q;
  end

  // Next-state: capture the in-flight word, pop on handshake, track occupancy.
  always_comb begin
    buf_d       = buf_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    words_out_d = words_out_q;
    inflight_d  = fifo_r_en;
    if (inflight_q) begin
      case (wr_ptr_q)
        2'd0:    buf_d[0] = fifo_data;
        2'd1:    buf_d[1] = fifo_data;
        2'd2:    buf_d[2] = fifo_data;
        default: buf_d[0] = buf_q[0];
      endcase
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d    = ptr_inc(rd_ptr_q);
      words_out_d = words_out_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d    = rd_ptr_q;
    end
    occ_d = occ_q + {1'b0, inflight_q} - {1'b0, pop_s};
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= '0;
      end
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      occ_q       <= 2'd0;
      inflight_q  <= 1'b0;
      words_out_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        buf_q[i] <= buf_d[i];
      end
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      words_out_q <= words_out_d;
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench: a behavioural FIFO feeds the reader; a monitor checks data order
// and the read/valid/busy/count behaviour against word-count bookkeeping.
module tb_fifo_stream_reader;

  logic       clk;
  logic       rst;
  logic       en;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_r_en;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic [3:0] words_out;
  logic       busy;

  fifo_stream_reader #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_r_en(fifo_r_en), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .words_out(words_out), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 8-deep FIFO with one-cycle read latency
  logic [7:0] mem [8];
  logic [2:0] f_wp, f_rp;
  logic [3:0] f_cnt;
  logic       w_en;
  logic [7:0] w_data;
  logic       f_rd, f_wr;
  logic [7:0] exp_q [$];

  assign f_rd       = fifo_r_en && (f_cnt != 4'd0);
  assign f_wr       = w_en && (f_cnt < 4'd8);
  assign fifo_empty = (f_cnt == 4'd0);

  always @(posedge clk) begin
    if (rst) begin
      f_cnt     <= 4'd0;
      f_wp      <= 3'd0;
      f_rp      <= 3'd0;
      fifo_data <= 8'd0;
      exp_q.delete();
    end else begin
      if (f_wr) begin
        mem[f_wp] <= w_data;
        f_wp      <= f_wp + 3'd1;
        exp_q.push_back(w_data);
      end
      if (f_rd) begin
        fifo_data <= mem[f_rp];
        f_rp      <= f_rp + 3'd1;
      end
      f_cnt <= f_cnt + {3'd0, f_wr} - {3'd0, f_rd};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: count-based reference of reads issued vs. words delivered
  int         issued = 0;
  int         delivered = 0;
  int         held;
  int         exp_occ;
  logic       ren_last = 1'b0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'd0;
  logic [7:0] exp_word;

  initial begin
    forever begin
      @(negedge clk);
      held    = issued - delivered;
      exp_occ = held - int'(ren_last);
      check("overflow", 32'(held <= 3), 32'd1);
      check("m_valid", 32'(m_valid), 32'(exp_occ > 0));
      check("busy", 32'(busy), 32'(held > 0));
      check("fifo_r_en", 32'(fifo_r_en), 32'(en && !rst && !fifo_empty && held < 3));
      check("words_out", 32'(words_out), 32'(delivered[3:0]));
      if (prev_stall && !rst) begin
        check("stall_data", 32'(m_data), 32'(prev_data));
      end
      if (m_valid && m_ready && !rst) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL m_data actual=%0h expected=none at %0t", m_data, $time);
        end else begin
          exp_word = exp_q.pop_front();
          check("m_data", 32'(m_data), 32'(exp_word));
        end
      end
      prev_stall = m_valid && !m_ready && !rst;
      prev_data  = m_data;
      if (rst) begin
        issued    = 0;
        delivered = 0;
        ren_last  = 1'b0;
      end else begin
        issued    = issued + int'(fifo_r_en);
        delivered = delivered + int'(m_valid && m_ready);
        ren_last  = fifo_r_en;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic push_word(input logic [7:0] v);
    int g = 0;
    while (f_cnt == 4'd8 && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 100) begin
      checks++;
      errors++;
      $display("FAIL push_timeout actual=full expected=space");
    end
    w_en = 1'b1;
    w_data = v;
    @(posedge clk); #1;
    w_en = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (!(busy == 1'b0 && fifo_empty && exp_q.size() == 0) && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 200) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=busy expected=idle");
    end
  endtask

  int         cyc, first_ren, first_val, vcount, gap, rcount, g;
  logic [7:0] first_word;
  logic [3:0] wo0, wd;

  initial begin
    rst = 1'b1; en = 1'b1; m_ready = 1'b0; w_en = 1'b0; w_data = 8'd0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_fifo_r_en", 32'(fifo_r_en), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_words_out", 32'(words_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; en = 1'b0; m_ready = 1'b1;

    // Streaming
    for (int i = 1; i <= 8; i++) push_word(8'(i));
    en = 1'b1;
    cyc = 0; first_ren = -1; first_val = -1; vcount = 0; gap = 0;
    while (vcount < 8 && cyc < 40) begin
      @(negedge clk);
      if (fifo_r_en && first_ren < 0) first_ren = cyc;
      if (m_valid) begin
        if (first_val < 0) first_val = cyc;
        vcount++;
      end else if (first_val >= 0) begin
        gap = 1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check("stream_latency", 32'(first_val - first_ren), 32'd2);
    check("stream_gap", 32'(gap), 32'd0);
    check("stream_count", 32'(vcount), 32'd8);
    wait_idle();
    check("stream_words_out", 32'(words_out), 32'd8);
    check("stream_empty", 32'(fifo_empty), 32'd1);

    // Backpressure
    m_ready = 1'b0; en = 1'b0;
    first_word = 8'($urandom);
    push_word(first_word);
    for (int i = 1; i < 8; i++) push_word(8'($urandom));
    en = 1'b1;
    rcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_r_en) rcount++;
      @(posedge clk); #1;
    end
    check("bp_reads", 32'(rcount), 32'd3);
    check("bp_hold_data", 32'(m_data), 32'(first_word));
    m_ready = 1'b1;
    wait_idle();

    // Disable mid-stream
    en = 1'b0;
    wo0 = words_out;
    for (int i = 0; i < 8; i++) push_word(8'($urandom));
    en = 1'b1;
    rcount = 0; g = 0;
    while (rcount < 3 && g < 30) begin
      @(negedge clk);
      if (fifo_r_en) rcount++;
      @(posedge clk); #1;
      g++;
    end
    en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("dis_no_read", 32'(fifo_r_en), 32'd0);
      @(posedge clk); #1;
    end
    wd = words_out - wo0;
    check("dis_delivered", 32'(wd), 32'd3);
    en = 1'b1;
    wait_idle();
    wd = words_out - wo0;
    check("dis_resume_total", 32'(wd), 32'd8);

    // Reset mid-operation with occ=2, inflight=1
    m_ready = 1'b0; en = 1'b0;
    for (int i = 0; i < 8; i++) push_word(8'($urandom));
    en = 1'b1;
    rcount = 0; g = 0;
    while (rcount < 3 && g < 30) begin
      @(negedge clk);
      if (fifo_r_en) rcount++;
      @(posedge clk); #1;
      g++;
    end
    rst = 1'b1;
    @(negedge clk);
    check("pre_rst_valid", 32'(m_valid), 32'd1);
    check("pre_rst_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_words_out", 32'(words_out), 32'd0);
    @(posedge clk); #1;

    // Counter wrap at CNT_W=4
    m_ready = 1'b1; en = 1'b1;
    for (int i = 0; i < 17; i++) push_word(8'($urandom));
    wait_idle();
    check("wrap_words_out", 32'(words_out), 32'd1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      en      = ($urandom_range(0, 9) < 8);
      m_ready = $urandom_range(0, 1) == 1;
      w_en    = $urandom_range(0, 2) != 0;
      w_data  = 8'($urandom);
      @(posedge clk); #1;
    end
    w_en = 1'b0; en = 1'b1; m_ready = 1'b1;
    wait_idle();
    check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side drain controller that sits directly downstream of `synchronous_fifo`. It pops words from the FIFO and absorbs the FIFO's one-cycle read latency in a 3-entry output buffer. It presents the words on a valid/ready stream with full throughput and no combinational path from `m_ready` to `fifo_r_en`. It also counts delivered words and flags activity for the surrounding bench and system.

## Interface
- `WIDTH`, 8: data width; equals the FIFO `DATA_WIDTH`.
- `CNT_W`, 16: width of the delivered-word counter.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high; takes effect on the rising edge of `clk`.
- `en` in 1: drain enable; when low, no new FIFO reads are issued.
- `fifo_empty` in 1: FIFO `empty` flag.
- `fifo_data` in WIDTH: FIFO `data_out`; valid in the cycle after a read.
- `fifo_r_en` out 1: FIFO `r_en`.
- `m_valid` out 1: output word available.
- `m_data` out WIDTH: output word.
- `m_ready` in 1: consumer accepts a word when high together with `m_valid`.
- `words_out` out CNT_W: number of completed output handshakes, modulo 2^CNT_W.
- `busy` out 1: a word is buffered or in flight.

## Operation
- **State**
  - 3-entry circular buffer: `wr_ptr` and `rd_ptr`, each 2 bits, wrapping 2→0.
  - `occ` (0..3).
  - `inflight` (1 bit).
  - `words_out` counter.
- **Reset values** (state after an edge with `rst`=1)
  - `occ`=0, `inflight`=0, both pointers 0, `words_out`=0.
  - Outputs: `m_valid`=0, `fifo_r_en`=0, `busy`=0.
  - `m_data` = buffer entry 0, which is cleared to 0.
- **Issue rule** (combinational from registered state and `fifo_empty` only)
  - `fifo_r_en` = `en` && !`rst` && !`fifo_empty` && (`occ` + `inflight` < 3).
  - A read is never issued while `fifo_empty`=1.
- **Capture**
  - `inflight` next = `fifo_r_en`.
  - When `inflight`=1, `fifo_data` is written to entry `wr_ptr` at the edge and `wr_ptr` advances.
- **Output**
  - `m_valid` = (`occ` != 0).
  - `m_data` = entry `rd_ptr`.
  - On a handshake (`m_valid` && `m_ready`), `rd_ptr` advances and `words_out` increments, wrapping from 2^CNT_W−1 to 0.
- **Occupancy**
  - `occ` next = `occ` + `inflight` − handshake.
  - A simultaneous capture and pop leaves `occ` unchanged.
  - The credit rule guarantees `occ` never exceeds 3; an overflow is a design error, and the bench asserts against it.
- **Busy:** `busy` = (`occ` != 0) || `inflight`.
- **`en` deassertion:** stops new reads only. An in-flight word is still captured, and the buffer keeps draining to the consumer.
- **Stall:** while `m_valid`=1 and `m_ready`=0, `m_data` and `m_valid` hold stable.
- **Reset mid-operation:** buffered and in-flight words are discarded. The FIFO contents are the FIFO's own concern, since it shares the reset domain.

## Timing
- Read latency:
  - `fifo_r_en` high in cycle N.
  - `fifo_data` captured at the end of cycle N+1.
  - `m_valid` high in cycle N+2.
- Minimum FIFO-to-stream latency is 2 cycles.
- Sustained throughput is 1 word/cycle when `en`=1, the FIFO is non-empty, and `m_ready`=1.
- Backpressure:
  - With `m_ready` held at 0, at most 3 words leave the FIFO.
  - `fifo_r_en` drops the cycle `occ` + `inflight` reaches 3.
- Restart after stall:
  - `m_ready` rising in cycle M pops a word at the end of M.
  - `fifo_r_en` may reassert in M+1.
  - No bubble appears on `m_valid`, because 2 words remain buffered.
- Output `m_data`/`m_valid` are register-driven.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles with FIFO non-empty → `fifo_r_en`=0, `m_valid`=0, `words_out`=0, `busy`=0.
- **Streaming:** write 0x01..0x08 into the FIFO (DEPTH 8), `en`=1, `m_ready`=1.
  - First `m_valid` appears 2 cycles after the first `fifo_r_en`.
  - 8 consecutive words 0x01..0x08 with no gaps.
  - `words_out`=8; FIFO `empty`=1; `busy` falls.
- **Backpressure:** 8 words in the FIFO, `m_ready`=0.
  - Exactly 3 `fifo_r_en` pulses; `m_data`=0x01 held.
  - Release `m_ready` → 0x01..0x08 in order; no loss, no duplication.
- **Disable mid-stream:** drop `en` after the 3rd `fifo_r_en`.
  - In-flight word is still delivered; no further reads.
  - Re-raise `en` → remaining words resume in order.
- **Reset mid-operation:** assert `rst` with `occ`=2 and `inflight`=1 → next cycle `m_valid`=0, `busy`=0, `words_out`=0.
- **Counter wrap:** with `CNT_W`=4, deliver 17 words → `words_out`=1. Random `m_ready` toggling yields in-order data.
